sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 136 +++++++++++++
 tb/tb_sdram_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM burst arbiter: round-robin between a frame write FIFO and a read FIFO,
// issuing one 512-word burst at a time to the SDRAM controller.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no burst in flight; wait for controller ready and a request
// ISSUE     | ctl_rw_en pulsed for one cycle with rw/addr already latched
// WAIT_ACK  | controller has not yet dropped ready for this burst
// WAIT_DONE | burst running; ready returning high marks completion
module sdram_arbiter #(
    parameter int FRAME_BURSTS = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [15:0] wr_data,
    output logic        wr_pop,
    input  logic        rd_req,
    output logic [15:0] rd_data,
    output logic        rd_push,
    output logic        ctl_rw,
    output logic        ctl_rw_en,
    output logic [14:0] ctl_addr,
    output logic [15:0] ctl_wdata,
    input  logic        ctl_wdata_req,
    input  logic [15:0] ctl_rdata,
    input  logic        ctl_rdata_valid,
    input  logic        ctl_ready,
    output logic        frame_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [14:0] LAST_PTR = 15'(FRAME_BURSTS - 1);

    state_t      r_state;
    logic [14:0] r_wr_ptr;
    logic [14:0] r_rd_ptr;
    logic        r_last_grant;   // 1 = read was granted last
    logic        r_frame_valid;
    logic        r_ctl_rw;
    logic        r_ctl_rw_en;
    logic [14:0] r_ctl_addr;

    logic        w_wr_elig;
    logic        w_rd_elig;
    logic        w_grant_rd;
    logic        w_any_elig;
    logic [14:0] w_wr_ptr_nxt;
    logic [14:0] w_rd_ptr_nxt;

    // FIFO data and strobes pass straight between FIFOs and controller
    assign wr_pop    = ctl_wdata_req;
    assign ctl_wdata = wr_data;
    assign rd_data   = ctl_rdata;
    assign rd_push   = ctl_rdata_valid;

    // Reads only make sense once a whole frame exists in SDRAM
    assign w_wr_elig  = wr_req;
    assign w_rd_elig  = rd_req & r_frame_valid;
    assign w_any_elig = w_wr_elig | w_rd_elig;
    assign w_grant_rd = w_rd_elig & (~w_wr_elig | ~r_last_grant);

    // Linear burst index: low two bits are the bank, so consecutive bursts rotate banks
    assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? 15'd0 : r_wr_ptr + 15'd1;
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? 15'd0 : r_rd_ptr + 15'd1;

    assign ctl_rw      = r_ctl_rw;
    assign ctl_rw_en   = r_ctl_rw_en;
    assign ctl_addr    = r_ctl_addr;
    assign frame_valid = r_frame_valid;
    assign busy        = (r_state != ST_IDLE);

    // Burst sequencing FSM with registered controller outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= 15'd0;
            r_rd_ptr      <= 15'd0;
            r_last_grant  <= 1'b1;
            r_frame_valid <= 1'b0;
            r_ctl_rw      <= 1'b0;
            r_ctl_rw_en   <= 1'b0;
            r_ctl_addr    <= 15'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ctl_rw_en <= 1'b0;
                    if (ctl_ready && w_any_elig) begin
                        r_state      <= ST_ISSUE;
                        r_ctl_rw_en  <= 1'b1;
                        r_last_grant <= w_grant_rd;
                        r_ctl_rw     <= w_grant_rd;
                        if (w_grant_rd) begin
                            r_ctl_addr <= r_rd_ptr;
                            r_rd_ptr   <= w_rd_ptr_nxt;
                        end else begin
                            r_ctl_addr <= r_wr_ptr;
                            r_wr_ptr   <= w_wr_ptr_nxt;
                            if (r_wr_ptr == LAST_PTR) begin
                                r_frame_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    r_ctl_rw_en <= 1'b0;
                    r_state     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    r_ctl_rw_en <= 1'b0;
                    if (!ctl_ready) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    r_ctl_rw_en <= 1'b0;
                    if (ctl_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ctl_rw_en <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small frame (4 bursts) and a
// hand-driven controller handshake.
module tb_sdram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        wr_pop;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_push;
    logic        ctl_rw;
    logic        ctl_rw_en;
    logic [14:0] ctl_addr;
    logic [15:0] ctl_wdata;
    logic        ctl_wdata_req;
    logic [15:0] ctl_rdata;
    logic        ctl_rdata_valid;
    logic        ctl_ready;
    logic        frame_valid;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_arbiter #(.FRAME_BURSTS(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_req          (wr_req),
        .wr_data         (wr_data),
        .wr_pop          (wr_pop),
        .rd_req          (rd_req),
        .rd_data         (rd_data),
        .rd_push         (rd_push),
        .ctl_rw          (ctl_rw),
        .ctl_rw_en       (ctl_rw_en),
        .ctl_addr        (ctl_addr),
        .ctl_wdata       (ctl_wdata),
        .ctl_wdata_req   (ctl_wdata_req),
        .ctl_rdata       (ctl_rdata),
        .ctl_rdata_valid (ctl_rdata_valid),
        .ctl_ready       (ctl_ready),
        .frame_valid     (frame_valid),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full burst handshake: wait for the issue pulse, check it, then hold
    // ready low for 'hold' cycles and release it.
    task automatic burst(input string tag, input logic exp_rw, input logic [14:0] exp_addr,
                         input logic exp_fv, input int hold);
        int n;
        int extra;
        n = 0;
        extra = 0;
        while (!ctl_rw_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_val({tag, "_issue"}, ctl_rw_en, 1);
        chk_val({tag, "_rw"}, ctl_rw, exp_rw);
        chk_val({tag, "_addr"}, ctl_addr, exp_addr);
        chk_val({tag, "_fv"}, frame_valid, exp_fv);
        chk_val({tag, "_busy"}, busy, 1);
        @(negedge clk);
        chk_val({tag, "_pulse1"}, ctl_rw_en, 0);
        ctl_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ctl_rw_en) extra++;
            if (ctl_addr !== exp_addr || ctl_rw !== exp_rw || !busy) extra++;
        end
        chk_val({tag, "_hold"}, extra, 0);
        ctl_ready = 1'b1;
        @(negedge clk);
        chk_val({tag, "_done"}, busy, 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        wr_data = 16'h0;
        ctl_wdata_req = 1'b0;
        ctl_rdata = 16'h0;
        ctl_rdata_valid = 1'b0;
        ctl_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_rw_en", ctl_rw_en, 0);
        chk_val("rst_rw", ctl_rw, 0);
        chk_val("rst_addr", ctl_addr, 0);
        chk_val("rst_fv", frame_valid, 0);

        // Reads are not eligible before a frame is written
        rst_n = 1'b1;
        rd_req = 1'b1;
        ctl_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ctl_rw_en || busy) cnt++;
        end
        chk_val("rd_before_frame", cnt, 0);

        // Four writes fill the frame, fifth wraps to address 0
        rd_req = 1'b0;
        wr_req = 1'b1;
        burst("w0", 1'b0, 15'd0, 1'b0, 3);
        burst("w1", 1'b0, 15'd1, 1'b0, 3);
        burst("w2", 1'b0, 15'd2, 1'b0, 3);
        burst("w3", 1'b0, 15'd3, 1'b1, 3);
        burst("w4", 1'b0, 15'd0, 1'b1, 3);

        // Both eligible: alternate starting with read (write was granted last)
        rd_req = 1'b1;
        burst("alt_r0", 1'b1, 15'd0, 1'b1, 4);
        burst("alt_w1", 1'b0, 15'd1, 1'b1, 4);
        burst("alt_r1", 1'b1, 15'd1, 1'b1, 4);
        burst("alt_w2", 1'b0, 15'd2, 1'b1, 4);

        // Read-only request
        wr_req = 1'b0;
        burst("rd_only", 1'b1, 15'd2, 1'b1, 2);

        // Ready low while idle (refresh) must not issue
        wr_req = 1'b1;
        rd_req = 1'b0;
        ctl_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ctl_rw_en || busy) cnt++;
        end
        chk_val("refresh_idle", cnt, 0);
        ctl_ready = 1'b1;
        burst("after_ref", 1'b0, 15'd3, 1'b1, 2);

        // Long controller hold; requests dropped mid-burst do not matter
        burst("long_hold", 1'b0, 15'd0, 1'b1, 20);
        wr_req = 1'b0;
        repeat (5) @(negedge clk);
        chk_val("no_req_idle", busy, 0);

        // Datapath pass-through
        cnt = 0;
        for (int i = 0; i < 512; i++) begin
            wr_data = 16'(i * 3 + 1);
            ctl_wdata_req = 1'b1;
            ctl_rdata = ~16'(i);
            ctl_rdata_valid = i[0];
            #1;
            if (wr_pop !== 1'b1 || ctl_wdata !== 16'(i * 3 + 1)) cnt++;
            if (rd_push !== i[0] || rd_data !== ~16'(i)) cnt++;
            @(negedge clk);
        end
        chk_val("datapath", cnt, 0);
        ctl_wdata_req = 1'b0;
        ctl_rdata_valid = 1'b0;
        #1;
        chk_val("wr_pop_off", wr_pop, 0);
        chk_val("rd_push_off", rd_push, 0);

        // Reset mid-burst
        wr_req = 1'b1;
        cnt = 0;
        while (!ctl_rw_en && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk_val("mid_issue", ctl_rw_en, 1);
        @(negedge clk);
        ctl_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_val("mid_rst_busy", busy, 0);
        chk_val("mid_rst_addr", ctl_addr, 0);
        chk_val("mid_rst_fv", frame_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ctl_rw_en || busy) cnt++;
        end
        chk_val("post_rst_quiet", cnt, 0);
        ctl_ready = 1'b1;
        burst("post_rst_w0", 1'b0, 15'd0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
